seg_display_arbiter: RTL and testbench

//  Owns the 4-digit 7-segment display and shares it between two 8-bit requesters: A = CPU out_reg path, B = debug/status.

---
 rtl/seg_display_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Shares a 4-digit 7-segment display between two 8-bit
//               requesters.
//               - req/ack arbitration with a minimum ownership hold time
//               - sequential double-dabble binary-to-BCD conversion
//               - digit scanning with dead-time blanking
//               - leading-zero suppression
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int SCAN_CYCLES  = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int HOLD_CYCLES  = 50000000
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic       owner,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] digit
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    state_t             state_q;
    logic               owner_q;
    logic               ack_a_q;
    logic               ack_b_q;
    logic               busy_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [19:0]        scratch_q;   // {hundreds, tens, units, binary}
    logic [3:0]         step_q;
    logic [11:0]        bcd_q;       // value currently shown

    logic [SCAN_W-1:0]  slot_q;
    logic [1:0]         idx_q;
    logic [7:0]         seg_q;
    logic [3:0]         digit_q;

    logic               grant_valid;
    logic               grant_owner_d;
    logic [7:0]         grant_data;
    logic [19:0]        dd_adj;
    logic [19:0]        dd_step_d;
    logic [7:0]         seg_d;
    logic [3:0]         digit_d;

    assign ack_a = ack_a_q;
    assign ack_b = ack_b_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign seg   = seg_q;
    assign digit = digit_q;

    // Active-low glyphs for decimal digits {dp,g..a}
    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    // Grant decision: a non-owner wins once the hold has expired, else owner only
    always_comb begin
        grant_valid   = 1'b0;
        grant_owner_d = owner_q;
        if (state_q == S_IDLE) begin
            if ((hold_q == '0) && (owner_q ? req_a : req_b)) begin
                grant_valid   = 1'b1;
                grant_owner_d = ~owner_q;
            end else if (owner_q ? req_b : req_a) begin
                grant_valid   = 1'b1;
            end
        end
        grant_data = grant_owner_d ? data_b : data_a;
    end

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left
    always_comb begin
        dd_adj = scratch_q;
        if (scratch_q[11:8] >= 4'd5)   dd_adj[11:8]  = scratch_q[11:8]  + 4'd3;
        if (scratch_q[15:12] >= 4'd5)  dd_adj[15:12] = scratch_q[15:12] + 4'd3;
        if (scratch_q[19:16] >= 4'd5)  dd_adj[19:16] = scratch_q[19:16] + 4'd3;
        dd_step_d = dd_adj << 1;
    end

    // Arbitration / conversion FSM with registered handshake outputs
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            scratch_q <= '0;
            step_q    <= '0;
            bcd_q     <= '0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;

            // Hold time restarts on every grant and runs down in any state
            if (grant_valid) begin
                hold_q <= HOLD_W'(HOLD_CYCLES);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        ack_a_q   <= ~grant_owner_d;
                        ack_b_q   <= grant_owner_d;
                        owner_q   <= grant_owner_d;
                        scratch_q <= {12'd0, grant_data};
                        step_q    <= '0;
                        state_q   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (step_q == 4'd8) begin
                        // Whole result published at once
                        bcd_q   <= scratch_q[19:8];
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        scratch_q <= dd_step_d;
                        step_q    <= step_q + 4'd1;
                        busy_q    <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Segment/digit pattern for the current scan position
    always_comb begin
        seg_d   = 8'hFF;
        digit_d = ~(4'b0001 << idx_q);
        case (idx_q)
            2'd0: seg_d = glyph(bcd_q[3:0]);
            2'd1: seg_d = ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) ? 8'hFF : glyph(bcd_q[7:4]);
            2'd2: seg_d = (bcd_q[11:8] == 4'd0) ? 8'hFF : glyph(bcd_q[11:8]);
            default: seg_d = owner_q ? 8'h7F : 8'hFF;
        endcase
        if (slot_q < SCAN_W'(BLANK_CYCLES)) begin
            seg_d   = 8'hFF;
            digit_d = 4'hF;
        end
    end

    // Free-running scan counter and registered display drive
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            slot_q  <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 8'hFF;
            digit_q <= 4'hF;
        end else begin
            if (slot_q == SCAN_W'(SCAN_CYCLES - 1)) begin
                slot_q <= '0;
                idx_q  <= idx_q + 2'd1;
            end else begin
                slot_q <= slot_q + SCAN_W'(1);
            end
            seg_q   <= seg_d;
            digit_q <= digit_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Directed self-checking bench for seg_display_arbiter
//               (SCAN_CYCLES=8, BLANK_CYCLES=2, HOLD_CYCLES=100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

    logic       clk_50mhz = 1'b0;
    logic       reset     = 1'b0;
    logic       req_a     = 1'b0;
    logic [7:0] data_a    = 8'd0;
    logic       ack_a;
    logic       req_b     = 1'b0;
    logic [7:0] data_b    = 8'd0;
    logic       ack_b;
    logic       owner;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] digit;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int n;
    int t_b;
    bit seen;

    seg_display_arbiter #(
        .SCAN_CYCLES (8),
        .BLANK_CYCLES(2),
        .HOLD_CYCLES (100)
    ) dut (
        .clk_50mhz(clk_50mhz),
        .reset    (reset),
        .req_a    (req_a),
        .data_a   (data_a),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .ack_b    (ack_b),
        .owner    (owner),
        .busy     (busy),
        .seg      (seg),
        .digit    (digit)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input bit sel_b, input int limit, output int cnt, output bit found);
        found = 1'b0;
        cnt   = 0;
        while (!found && cnt < limit) begin
            tick();
            cnt++;
            if ((sel_b ? ack_b : ack_a) === 1'b1) found = 1'b1;
        end
    endtask

    task automatic wait_digit(input logic [3:0] val, output bit found);
        found = 1'b0;
        for (int i = 0; i < 48 && !found; i++) begin
            if (digit === val) found = 1'b1;
            else tick();
        end
    endtask

    // Align to the start of the units slot and check one full frame
    task automatic check_frame(input string tag, input logic [7:0] u, input logic [7:0] t,
                               input logic [7:0] h, input logic [7:0] s3);
        bit f;
        wait_digit(4'hF, f);
        wait_digit(4'hE, f);
        chk({tag, "_sync"}, f, 1);
        chk({tag, "_units"}, seg, u);
        repeat (6) tick();
        chk({tag, "_blank_dig"}, digit, 4'hF);
        chk({tag, "_blank_seg"}, seg, 8'hFF);
        repeat (2) tick();
        chk({tag, "_tens_dig"}, digit, 4'hD);
        chk({tag, "_tens"}, seg, t);
        repeat (8) tick();
        chk({tag, "_hund_dig"}, digit, 4'hB);
        chk({tag, "_hund"}, seg, h);
        repeat (8) tick();
        chk({tag, "_own_dig"}, digit, 4'h7);
        chk({tag, "_own"}, seg, s3);
    endtask

    // Single-requester transaction with handshake and busy-window checks
    task automatic grant(input bit sel_b, input logic [7:0] val, input string tag);
        int  c;
        bit  f;
        if (sel_b) begin data_b = val; req_b = 1'b1; end
        else       begin data_a = val; req_a = 1'b1; end
        wait_ack(sel_b, 200, c, f);
        chk({tag, "_ack"}, f, 1);
        chk({tag, "_other_ack"}, sel_b ? ack_a : ack_b, 0);
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        chk({tag, "_ack_pulse"}, sel_b ? ack_b : ack_a, 0);
        chk({tag, "_busy_first"}, busy, 1);
        repeat (7) tick();
        chk({tag, "_busy_last"}, busy, 1);
        tick();
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        // 1: reset state and empty display
        #2;
        reset = 1'b1;
        #1;
        chk("rst_seg", seg, 8'hFF);
        chk("rst_digit", digit, 4'hF);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_ack_b", ack_b, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        check_frame("f_reset", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // 2/3: conversions from requester A
        grant(1'b0, 8'd255, "a255");
        chk("a255_owner", owner, 0);
        check_frame("f255", 8'h92, 8'h92, 8'hA4, 8'hFF);
        grant(1'b0, 8'd7, "a7");
        check_frame("f7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
        grant(1'b0, 8'd100, "a100");
        check_frame("f100", 8'hC0, 8'hC0, 8'hF9, 8'hFF);
        grant(1'b0, 8'd99, "a99");
        check_frame("f99", 8'h90, 8'h90, 8'hFF, 8'hFF);

        // 4: simultaneous requests after reset -> B first, A after hold
        do_reset();
        data_a = 8'd3;
        data_b = 8'd5;
        req_a  = 1'b1;
        req_b  = 1'b1;
        tick();
        chk("rr_ack_b", ack_b, 1);
        chk("rr_ack_a", ack_a, 0);
        chk("rr_owner_b", owner, 1);
        t_b   = cyc;
        req_b = 1'b0;
        repeat (10) tick();
        chk("rr_busy_done", busy, 0);
        check_frame("f_b5", 8'h92, 8'hFF, 8'hFF, 8'h7F);
        wait_ack(1'b0, 200, n, seen);
        chk("rr_ack_a_seen", seen, 1);
        chk("rr_hold_respected", (cyc - t_b) >= 100, 1);
        chk("rr_owner_a", owner, 0);
        req_a = 1'b0;
        repeat (10) tick();
        check_frame("f_a3", 8'hB0, 8'hFF, 8'hFF, 8'hFF);

        // 5: owner re-request pending through CONVERT, non-owner waits for hold
        do_reset();
        data_b = 8'd9;
        req_b  = 1'b1;
        tick();
        chk("h_ack_b1", ack_b, 1);
        chk("h_owner_b", owner, 1);
        req_b = 1'b0;
        repeat (5) tick();
        data_b = 8'd42;
        req_b  = 1'b1;
        data_a = 8'd1;
        req_a  = 1'b1;
        wait_ack(1'b1, 20, n, seen);
        chk("h_ack_b2_seen", seen, 1);
        chk("h_ack_b2_latency", n, 5);
        chk("h_ack_a_waits", ack_a, 0);
        t_b   = cyc;
        req_b = 1'b0;
        repeat (10) tick();
        check_frame("f42", 8'hA4, 8'h99, 8'hFF, 8'h7F);
        wait_ack(1'b0, 200, n, seen);
        chk("h_ack_a_seen", seen, 1);
        chk("h_hold_respected", (cyc - t_b) >= 100, 1);
        chk("h_owner_a", owner, 0);
        req_a = 1'b0;

        // 6: reset in the middle of a conversion aborts it
        do_reset();
        data_a = 8'd200;
        req_a  = 1'b1;
        wait_ack(1'b0, 20, n, seen);
        chk("ab_ack_seen", seen, 1);
        req_a = 1'b0;
        repeat (4) tick();
        chk("ab_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        chk("ab_busy_rst", busy, 0);
        chk("ab_ack_rst", ack_a, 0);
        chk("ab_seg_rst", seg, 8'hFF);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("ab_no_ack", ack_a, 0);
        check_frame("f_abort", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        grant(1'b0, 8'd200, "a200");
        check_frame("f200", 8'hC0, 8'hC0, 8'hA4, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
